// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready streaming on both sides.
// Stage 1 registers per-bit generate/propagate; stage 2 resolves carries and registers sum/cout/ovf.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_cin, s1_valid, s1_ready;
  logic             in_fire, out_load;

  // Handshake: a transfer happens on a side when valid && ready on the same rising edge;
  // valid never depends on ready, and ready flows combinationally upstream from out_ready.
  assign s1_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_load = s1_valid && s1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_g     <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_g     <= a & b;
      s1_p     <= a ^ b;
      s1_cin   <= cin;
      s1_valid <= 1'b1;
    end else if (s1_ready) begin
      s1_valid <= 1'b0;
    end
  end

  logic [NG-1:0] gg, gp;
  logic          gg_acc, gg_term;

  always_comb begin
    gg      = '0;
    gp      = '0;
    gg_acc  = 1'b0;
    gg_term = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gg_acc = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        gg_term = s1_g[k*GROUP+i];
        for (int m = i + 1; m < GROUP; m++) gg_term = gg_term & s1_p[k*GROUP+m];
        gg_acc = gg_acc | gg_term;
      end
      gg[k] = gg_acc;
      gp[k] = &s1_p[k*GROUP +: GROUP];
    end
  end

  // Group carries are flattened sums of products so no carry ripples between groups.
  logic [NG:0] gc;
  logic        gc_acc, gc_term;

  always_comb begin
    gc      = '0;
    gc_acc  = 1'b0;
    gc_term = 1'b0;
    gc[0]   = s1_cin;
    for (int k = 0; k < NG; k++) begin
      gc_acc = s1_cin;
      for (int m = 0; m <= k; m++) gc_acc = gc_acc & gp[m];
      for (int j = 0; j <= k; j++) begin
        gc_term = gg[j];
        for (int m = j + 1; m <= k; m++) gc_term = gc_term & gp[m];
        gc_acc = gc_acc | gc_term;
      end
      gc[k+1] = gc_acc;
    end
  end

  logic [WIDTH:0] c;
  logic           bc_acc, bc_term;

  always_comb begin
    c        = '0;
    bc_acc   = 1'b0;
    bc_term  = 1'b0;
    c[WIDTH] = gc[NG];
    for (int k = 0; k < NG; k++) begin
      c[k*GROUP] = gc[k];
      for (int i = 0; i < GROUP - 1; i++) begin
        bc_acc = gc[k];
        for (int m = 0; m <= i; m++) bc_acc = bc_acc & s1_p[k*GROUP+m];
        for (int j = 0; j <= i; j++) begin
          bc_term = s1_g[k*GROUP+j];
          for (int m = j + 1; m <= i; m++) bc_term = bc_term & s1_p[k*GROUP+m];
          bc_acc = bc_acc | bc_term;
        end
        c[k*GROUP+i+1] = bc_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      sum       <= s1_p ^ c[WIDTH-1:0];
      cout      <= c[WIDTH];
      ovf       <= c[WIDTH] ^ c[WIDTH-1];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: reset, corner additions, backpressure stream, mid-stream reset.
module tb_cla_pipe_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [1:0]  exp_flags_q[$];

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single directed add with out_ready held high; result must appear after the second edge.
  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic [15:0] esum, input logic ecout, input logic eovf,
                        input string tag);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, "_valid_n1"}, out_valid, 0);
    step();
    check({tag, "_valid_n2"}, out_valid, 1);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_ovf"}, ovf, eovf);
    step();
  endtask

  logic [15:0] va[8];
  logic [15:0] vb[8];
  logic        vc[8];
  logic [15:0] ready_pat;
  logic [16:0] full;
  logic [15:0] e_sum, prev_sum;
  logic [1:0]  e_fl;
  logic        in_fire, out_fire, prev_stall, e_ovf;
  int          idx, popped;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_in_ready", in_ready, 1);
    end
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_prop");
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "add_ones_cin");
    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf_pos");
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "add_ovf_neg");
    do_add(16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, "add_group_carry");

    // Backpressure stream.
    va[0] = 16'hA5A5; vb[0] = 16'h5A5B; vc[0] = 1'b0;
    va[1] = 16'h7FFF; vb[1] = 16'h7FFF; vc[1] = 1'b1;
    va[2] = 16'h0000; vb[2] = 16'h0000; vc[2] = 1'b1;
    va[3] = 16'hFFF0; vb[3] = 16'h0010; vc[3] = 1'b0;
    va[4] = 16'h8001; vb[4] = 16'hFFFF; vc[4] = 1'b0;
    va[5] = 16'h1357; vb[5] = 16'h2468; vc[5] = 1'b1;
    va[6] = 16'hC000; vb[6] = 16'hC000; vc[6] = 1'b0;
    va[7] = 16'h00FF; vb[7] = 16'hFF00; vc[7] = 1'b1;
    ready_pat = 16'b1011_0010_1101_0011;
    idx = 0; popped = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int cyc = 0; cyc < 200 && popped < 8; cyc++) begin
      out_ready = ready_pat[cyc % 16];
      in_valid  = (idx < 8);
      if (idx < 8) begin a = va[idx]; b = vb[idx]; cin = vc[idx]; end
      #1;
      if (prev_stall) begin
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_sum", sum, prev_sum);
      end
      check("bp_in_ready", in_ready, (exp_q.size() == 2 && !out_ready) ? 0 : 1);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check("bp_spurious_out", 1, 0);
        end else begin
          e_sum = exp_q.pop_front();
          e_fl  = exp_flags_q.pop_front();
          check("bp_sum", sum, e_sum);
          check("bp_cout", cout, e_fl[1]);
          check("bp_ovf", ovf, e_fl[0]);
          popped++;
        end
      end
      if (in_fire) begin
        full  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        e_ovf = (a[15] == b[15]) && (full[15] != a[15]);
        exp_q.push_back(full[15:0]);
        exp_flags_q.push_back({full[16], e_ovf});
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      @(posedge clk);
      #1;
    end
    check("bp_all_results", popped, 8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    // Two items in flight, then an asynchronous reset pulse.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    step();
    a = 16'h3333; b = 16'h4444;
    step();
    in_valid = 1'b0;
    check("mid_full_valid", out_valid, 1);
    check("mid_full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_stale", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
